factorial_batch_ctrl: RTL and testbench
=======================================

# factorial_batch_ctrl

Batch sequencer between a host and the factorial core. It takes a start value and a count. It issues one factorial job per value to the core over the core's ap_start/ap_done handshake and buffers each (n, n!) result in a small FIFO. The results drain through a valid/ready stream. To the host it exposes the same ap_start/ap_done/ap_idle/ap_ready block-level protocol as the core. A per-job watchdog flags a core that never completes.

## Interface
Parameters:
- FIFO_DEPTH, 4: result FIFO entries; power of two, minimum 2.
- TIMEOUT, 1024: cycles allowed from core_start to core_done before a job is abandoned.

Ports:
- ap_clk  in  1  sole clock; all state on rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  host request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse: batch complete and FIFO drained.
- ap_idle  out  1  combinational: state==IDLE && !ap_start.
- ap_ready  out  1  equal to ap_done.
- n_first  in  32  first argument; captured at start.
- n_count  in  8  number of jobs; captured at start; 0 is legal.
- core_start  out  1  one-cycle start pulse to the core.
- core_num  out  32  argument to the core; held stable from core_start until core_done.
- core_done  in  1  core completion pulse.
- core_return  in  32  core result; valid when core_done=1.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  downstream accept.
- res_n  out  32  argument of the head entry.
- res_data  out  32  factorial (mod 2^32) of the head entry.
- res_err  out  1  head entry was produced by watchdog timeout; res_data=0.

## Operation
- State machine: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - On ap_start=1, capture n_first into next_n and n_count into remaining.
  - If remaining=0, go to FINISH; otherwise go to ISSUE.
- ISSUE:
  - If fifo_count < FIFO_DEPTH, pulse core_start=1 for exactly one cycle with core_num=next_n.
  - Clear the watchdog and go to WAIT.
  - Otherwise stall in ISSUE with core_start=0.
- WAIT:
  - Only one job is ever outstanding.
  - On core_done=1, push {next_n, core_return, err=0} and advance the job.
  - If the watchdog reaches TIMEOUT-1 without core_done, push {next_n, 0, err=1} and advance the job.
  - Advancing a job means: next_n += 1 (wraps mod 2^32), remaining -= 1. Go to ISSUE if remaining>0 after the decrement; otherwise go to FINISH.
  - A core_done that arrives outside WAIT is ignored.
- FINISH: when fifo_count=0, pulse ap_done=ap_ready=1 for one cycle and go to IDLE.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy counter.
  - A push and a pop in the same cycle leave the count unchanged.
  - Overflow is impossible: ISSUE reserves space before each job.
  - res_n, res_data and res_err always present the head entry and hold stable while res_valid && !res_ready.
- ap_start is ignored outside IDLE. n_first and n_count may change freely after capture.

## Timing
- Reset (async assert, sync-released): state=IDLE, FIFO empty.
  - ap_done=ap_ready=core_start=res_valid=res_err=0; core_num=0, res_n=0, res_data=0.
  - ap_idle = !ap_start.
- Start latency: ap_start high at edge T gives core_start=1 in cycle T+1, provided the FIFO has space.
- Result latency:
  - core_done at edge D pushes the FIFO at D; res_valid=1 from D+1 if the FIFO was empty.
  - The next core_start follows at D+1 when space is available.
- Completion: ap_done is asserted the cycle after the last pop, or after the last push if that entry is popped in the same cycle. For n_count=0, ap_done is asserted in cycle T+1.
- Reset mid-batch: the outstanding job is abandoned and the FIFO is flushed. A core_done after reset release is ignored because the block is in IDLE.
- Watchdog: exactly TIMEOUT cycles from the core_start cycle to the push of the error entry.

## Test plan
- n_first=3, n_count=4, behavioural core (latency n+2), res_ready=1: four core_start pulses with core_num 3,4,5,6; stream (3,6), (4,24), (5,120), (6,720), all err=0; one ap_done pulse after the 4th pop; ap_idle=1 afterwards.
- n_count=0 with ap_start pulsed: no core_start; ap_done=ap_ready=1 exactly one cycle after the start edge.
- FIFO_DEPTH=4, n_first=0, n_count=8, res_ready=0: the fifth job stalls in ISSUE with core_start=0; head stays (0,1) stable. Then raise res_ready: the remaining jobs issue; the stream is 0..7 with data 1,1,2,6,24,120,720,5040.
- Core model never asserts core_done for n=2, TIMEOUT=16, n_first=1, n_count=3: entries (1,1,err0), (2,0,err1), (3,6,err0); the error entry is pushed exactly 16 cycles after its core_start.
- ap_rst asserted while in WAIT with 2 entries queued: outputs go to reset values immediately, FIFO empty. A late core_done produces no entry and the state stays IDLE.
- n_first=32'hFFFFFFFF, n_count=2: core_num sequence 0xFFFFFFFF, 0x00000000; res_n matches; ap_start pulses during the batch have no effect.

Source files
------------

// File: rtl/factorial_batch_ctrl_if.sv
// Host, core and result-stream signals of the factorial batch sequencer.
// slave is the sequencer itself; master is the host/core/result-sink side.
interface factorial_batch_ctrl_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [31:0] n_first;
  logic [7:0]  n_count;
  logic        core_start;
  logic [31:0] core_num;
  logic        core_done;
  logic [31:0] core_return;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_n;
  logic [31:0] res_data;
  logic        res_err;

  modport slave (
    input  ap_start, n_first, n_count, core_done, core_return, res_ready,
    output ap_done, ap_idle, ap_ready, core_start, core_num,
           res_valid, res_n, res_data, res_err
  );

  modport master (
    output ap_start, n_first, n_count, core_done, core_return, res_ready,
    input  ap_done, ap_idle, ap_ready, core_start, core_num,
           res_valid, res_n, res_data, res_err
  );
endinterface

// File: rtl/factorial_batch_ctrl.sv
// Batch sequencer: issues one factorial job per argument to the core, queues
// (n, n!) results in a small FIFO and drains them over a valid/ready stream.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for ap_start; captures n_first / n_count
// ISSUE   | pulses core_start once the FIFO has room for the result
// WAIT    | one job outstanding; ends on core_done or watchdog expiry
// FINISH  | all jobs pushed; waits for FIFO to drain, then pulses ap_done
module factorial_batch_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  factorial_batch_ctrl_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WDOG_LOAD = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [31:0]     next_n_q;
  logic [7:0]      remaining_q;
  logic [WW-1:0]   wdog_q;

  logic [31:0]     mem_n    [FIFO_DEPTH];
  logic [31:0]     mem_data [FIFO_DEPTH];
  logic            mem_err  [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            issue;
  logic            push;
  logic            push_err;
  logic            pop;
  logic            done_pulse;
  logic            fifo_nempty;

  assign fifo_nempty = (count_q != '0);
  assign pop         = fifo_nempty && bus.res_ready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    push       = 1'b0;
    push_err   = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          state_d = (bus.n_count == 8'd0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Space is reserved here so the eventual push can never overflow.
        if (count_q < DEPTH_C) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.core_done) begin
          push = 1'b1;
        end else if (wdog_q == '0) begin
          push     = 1'b1;
          push_err = 1'b1;
        end
        if (push) begin
          state_d = (remaining_q > 8'd1) ? S_ISSUE : S_FINISH;
        end
      end
      S_FINISH: begin
        if (count_q == '0) begin
          done_pulse = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog counts down from TIMEOUT-1; expiry at zero lands the error
  // entry exactly TIMEOUT cycles after the core_start cycle.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      next_n_q    <= '0;
      remaining_q <= '0;
      wdog_q      <= '0;
    end else begin
      if (state_q == S_IDLE && bus.ap_start) begin
        next_n_q    <= bus.n_first;
        remaining_q <= bus.n_count;
      end
      if (issue) begin
        wdog_q <= WDOG_LOAD;
      end else if (state_q == S_WAIT && wdog_q != '0) begin
        wdog_q <= wdog_q - 1'b1;
      end
      if (push) begin
        next_n_q    <= next_n_q + 32'd1;
        remaining_q <= remaining_q - 8'd1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_n[wr_ptr_q]    <= next_n_q;
      mem_data[wr_ptr_q] <= push_err ? 32'd0 : bus.core_return;
      mem_err[wr_ptr_q]  <= push_err;
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign bus.res_valid  = fifo_nempty;
  assign bus.res_n      = fifo_nempty ? mem_n[rd_ptr_q]    : 32'd0;
  assign bus.res_data   = fifo_nempty ? mem_data[rd_ptr_q] : 32'd0;
  assign bus.res_err    = fifo_nempty ? mem_err[rd_ptr_q]  : 1'b0;

  assign bus.core_start = issue;
  assign bus.core_num   = next_n_q;
  assign bus.ap_done    = done_pulse;
  assign bus.ap_ready   = done_pulse;
  assign bus.ap_idle    = (state_q == S_IDLE) && !bus.ap_start;

endmodule

// File: tb/tb_factorial_batch_ctrl.sv
// Directed bench for factorial_batch_ctrl with a behavioural factorial core.
module tb_factorial_batch_ctrl;

  localparam int TO = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] n;
    logic [31:0] data;
  } ent_t;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   checks   = 0;
  int   failures = 0;

  factorial_batch_ctrl_if bus();

  factorial_batch_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r;
    r = 32'd1;
    if (n >= 32'd34) return 32'd0;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction

  // Behavioural core: latency grows with n, optional never-finishing argument.
  logic        skip_en = 1'b0;
  logic [31:0] skip_n  = 32'd0;
  logic        m_busy;
  logic [31:0] m_n;
  int          m_cnt;

  initial begin
    bus.core_done   = 1'b0;
    bus.core_return = 32'd0;
    m_busy = 1'b0;
    m_n    = 32'd0;
    m_cnt  = 0;
    forever begin
      @(posedge ap_clk);
      bus.core_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          bus.core_done   <= 1'b1;
          bus.core_return <= fact(m_n);
          m_busy = 1'b0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else if (bus.core_start === 1'b1) begin
        if (!(skip_en && bus.core_num == skip_n)) begin
          m_busy = 1'b1;
          m_n    = bus.core_num;
          m_cnt  = (bus.core_num > 32'd7) ? 9 : int'(bus.core_num) + 2;
        end
      end
    end
  end

  // Monitor samples mid-low-phase, after the main process has driven inputs.
  logic [31:0] cs_q[$];
  int          cs_cyc_q[$];
  ent_t        pop_q[$];
  int          pop_cyc_q[$];
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          rdy_bad  = 0;

  always @(negedge ap_clk) begin
    #2;
    cyc = cyc + 1;
    if (bus.core_start === 1'b1) begin
      cs_q.push_back(bus.core_num);
      cs_cyc_q.push_back(cyc);
    end
    if (bus.ap_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (bus.ap_ready !== bus.ap_done) rdy_bad = rdy_bad + 1;
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      pop_q.push_back({bus.res_err, bus.res_n, bus.res_data});
      pop_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [31:0] cs_at(input int i);
    if (i < cs_q.size()) return cs_q[i];
    return 32'hFFFF_FFF0;
  endfunction

  function automatic int cs_cyc_at(input int i);
    if (i < cs_cyc_q.size()) return cs_cyc_q[i];
    return -1000;
  endfunction

  function automatic int pop_cyc_at(input int i);
    if (i < pop_cyc_q.size()) return pop_cyc_q[i];
    return -1000;
  endfunction

  task automatic clr();
    cs_q.delete();
    cs_cyc_q.delete();
    pop_q.delete();
    pop_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ent(input string tag, input int idx, input logic [31:0] n,
                         input logic [31:0] d, input logic e);
    ent_t got;
    got = '1;
    if (idx < pop_q.size()) got = pop_q[idx];
    checks++;
    assert (got === {e, n, d}) else begin
      failures++;
      $error("FAIL %s: observed err=%b n=%0h data=%0h expected err=%b n=%0h data=%0h",
             tag, got.err, got.n, got.data, e, n, d);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge ap_clk);
      #3;
      n++;
    end
    checks++;
    assert (done_cnt != start) else begin
      failures++;
      $error("FAIL %s: observed no ap_done in %0d cycles expected ap_done", tag, budget);
    end
  endtask

  task automatic wait_cs(input string tag, input int want, input int budget);
    int n;
    n = 0;
    while (cs_q.size() < want && n < budget) begin
      @(negedge ap_clk);
      #3;
      n++;
    end
    checks++;
    assert (cs_q.size() >= want) else begin
      failures++;
      $error("FAIL %s: observed %0d core_start pulses expected %0d", tag, cs_q.size(), want);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge ap_clk);
    #3;
  endtask

  // ap_start sampled at the edge after the first negedge; returns in cycle T+1.
  task automatic start_batch(input logic [31:0] nf, input logic [7:0] nc);
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.n_first  = nf;
    bus.n_count  = nc;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    bus.n_first  = 32'hDEAD_BEEF;
    bus.n_count  = 8'hAA;
  endtask

  logic [31:0] f_tbl [8] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040};

  initial begin
    int k;
    ap_rst        = 1'b1;
    bus.ap_start  = 1'b0;
    bus.n_first   = 32'd0;
    bus.n_count   = 8'd0;
    bus.res_ready = 1'b1;
    clr();

    // Reset values
    repeat (3) @(negedge ap_clk);
    #1;
    chk1("rst_ap_done", bus.ap_done, 1'b0);
    chk1("rst_ap_ready", bus.ap_ready, 1'b0);
    chk1("rst_core_start", bus.core_start, 1'b0);
    chk1("rst_res_valid", bus.res_valid, 1'b0);
    chk1("rst_res_err", bus.res_err, 1'b0);
    chk32("rst_core_num", bus.core_num, 32'd0);
    chk32("rst_res_n", bus.res_n, 32'd0);
    chk32("rst_res_data", bus.res_data, 32'd0);
    chk1("rst_ap_idle", bus.ap_idle, 1'b1);
    bus.ap_start = 1'b1;
    #1;
    chk1("rst_ap_idle_start", bus.ap_idle, 1'b0);
    bus.ap_start = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    idle_cycles(2);

    // Basic batch 3..6
    clr();
    start_batch(32'd3, 8'd4);
    #1;
    chk1("t1_start_latency", bus.core_start, 1'b1);
    chk32("t1_first_num", bus.core_num, 32'd3);
    chk1("t1_busy_idle", bus.ap_idle, 1'b0);
    wait_done("t1_done", 300);
    idle_cycles(3);
    chk32("t1_cs_count", cs_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk32("t1_core_num", cs_at(i), 32'd3 + 32'(i));
    chk_ent("t1_e0", 0, 32'd3, 32'd6, 1'b0);
    chk_ent("t1_e1", 1, 32'd4, 32'd24, 1'b0);
    chk_ent("t1_e2", 2, 32'd5, 32'd120, 1'b0);
    chk_ent("t1_e3", 3, 32'd6, 32'd720, 1'b0);
    chk32("t1_pop_count", pop_q.size(), 32'd4);
    chk32("t1_done_pulses", done_cnt, 32'd1);
    chk32("t1_done_after_pop", done_cyc, pop_cyc_at(3) + 1);
    chk1("t1_idle_after", bus.ap_idle, 1'b1);

    // Empty batch
    clr();
    start_batch(32'd7, 8'd0);
    #1;
    chk1("t2_ap_done", bus.ap_done, 1'b1);
    chk1("t2_ap_ready", bus.ap_ready, 1'b1);
    chk1("t2_no_core_start", bus.core_start, 1'b0);
    @(negedge ap_clk);
    #1;
    chk1("t2_done_one_cycle", bus.ap_done, 1'b0);
    chk1("t2_idle", bus.ap_idle, 1'b1);
    idle_cycles(3);
    chk32("t2_cs_count", cs_q.size(), 32'd0);
    chk32("t2_done_pulses", done_cnt, 32'd1);

    // Back-pressure: FIFO fills, fifth job stalls
    clr();
    bus.res_ready = 1'b0;
    start_batch(32'd0, 8'd8);
    idle_cycles(80);
    chk32("t3_stall_cs_count", cs_q.size(), 32'd4);
    chk1("t3_stall_core_start", bus.core_start, 1'b0);
    chk1("t3_head_valid", bus.res_valid, 1'b1);
    chk32("t3_head_n", bus.res_n, 32'd0);
    chk32("t3_head_data", bus.res_data, 32'd1);
    chk1("t3_head_err", bus.res_err, 1'b0);
    idle_cycles(5);
    chk32("t3_head_n_stable", bus.res_n, 32'd0);
    chk32("t3_head_data_stable", bus.res_data, 32'd1);
    @(negedge ap_clk);
    bus.res_ready = 1'b1;
    wait_done("t3_done", 400);
    idle_cycles(3);
    chk32("t3_cs_count", cs_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk_ent("t3_entry", i, 32'(i), f_tbl[i], 1'b0);
    chk32("t3_done_pulses", done_cnt, 32'd1);

    // Watchdog on n=2
    clr();
    skip_en = 1'b1;
    skip_n  = 32'd2;
    start_batch(32'd1, 8'd3);
    wait_done("t4_done", 300);
    idle_cycles(3);
    skip_en = 1'b0;
    chk_ent("t4_e0", 0, 32'd1, 32'd1, 1'b0);
    chk_ent("t4_e1_timeout", 1, 32'd2, 32'd0, 1'b1);
    chk_ent("t4_e2", 2, 32'd3, 32'd6, 1'b0);
    chk32("t4_cs_count", cs_q.size(), 32'd3);
    // Push lands TO edges after the core_start cycle; pop is seen one cycle later.
    chk32("t4_timeout_cycles", pop_cyc_at(1) - cs_cyc_at(1), 32'(TO + 1));

    // Reset while a job is outstanding with two entries queued
    clr();
    bus.res_ready = 1'b0;
    start_batch(32'd3, 8'd4);
    wait_cs("t5_third_start", 3, 200);
    @(negedge ap_clk);
    @(negedge ap_clk);
    #1;
    chk1("t5_pre_valid", bus.res_valid, 1'b1);
    chk32("t5_pre_head_n", bus.res_n, 32'd3);
    ap_rst = 1'b1;
    #1;
    chk1("t5_rst_valid", bus.res_valid, 1'b0);
    chk32("t5_rst_res_n", bus.res_n, 32'd0);
    chk32("t5_rst_res_data", bus.res_data, 32'd0);
    chk32("t5_rst_core_num", bus.core_num, 32'd0);
    chk1("t5_rst_core_start", bus.core_start, 1'b0);
    chk1("t5_rst_idle", bus.ap_idle, 1'b1);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    idle_cycles(20);
    chk1("t5_late_done_valid", bus.res_valid, 1'b0);
    chk1("t5_late_done_idle", bus.ap_idle, 1'b1);
    chk32("t5_cs_count", cs_q.size(), 32'd3);
    chk32("t5_done_pulses", done_cnt, 32'd0);

    // Argument wrap-around; ap_start pulses mid-batch are ignored
    clr();
    bus.res_ready = 1'b1;
    start_batch(32'hFFFF_FFFF, 8'd2);
    bus.n_first = 32'd5;
    bus.n_count = 8'd9;
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      @(negedge ap_clk);
      bus.ap_start = (k == 2 || k == 5 || k == 9);
      k++;
      #3;
    end
    bus.ap_start = 1'b0;
    chk32("t6_done_seen", done_cnt, 32'd1);
    idle_cycles(5);
    chk32("t6_cs_count", cs_q.size(), 32'd2);
    chk32("t6_num0", cs_at(0), 32'hFFFF_FFFF);
    chk32("t6_num1", cs_at(1), 32'h0000_0000);
    chk_ent("t6_e0", 0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    chk_ent("t6_e1", 1, 32'd0, 32'd1, 1'b0);
    chk32("t6_done_pulses", done_cnt, 32'd1);
    chk1("t6_idle", bus.ap_idle, 1'b1);

    chk32("ap_ready_tracks_ap_done", rdy_bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no completion expected completion before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
